// File: rtl/lsu_pkg.sv
// Shared load/store definitions: FSM states, access-size encodings and
// small helpers for legality checking and byte-enable generation.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        ERR  = 2'd3
    } lsu_state_e;

    // Access-size encodings, also produced by the instruction decoder.
    localparam logic [3:0] SIZE_B = 4'b0001;
    localparam logic [3:0] SIZE_H = 4'b0011;
    localparam logic [3:0] SIZE_W = 4'b1111;

    // Naturally-aligned check: a halfword may not straddle a word, a word must be aligned.
    function automatic logic lsu_size_legal(input logic [3:0] size, input logic [1:0] off);
        logic legal;
        case (size)
            SIZE_B:  legal = 1'b1;
            SIZE_H:  legal = (off != 2'd3);
            SIZE_W:  legal = (off == 2'd0);
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Byte enables are the size mask moved up to the addressed lane.
    function automatic logic [3:0] lsu_byte_en(input logic [3:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = size << off;
        return be;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: moves the addressed bytes of the raw DMEM
// word down to bit 0 and sign- or zero-extends them to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [3:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted_s;

    // Right-align the addressed lanes, then extend according to access size.
    always_comb begin
        shifted_s = rdata_i >> {off_i, 3'b000};
        case (size_i)
            SIZE_B: begin
                if (unsigned_i) begin
                    result_o = {24'h000000, shifted_s[7:0]};
                end else begin
                    result_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end
            end
            SIZE_H: begin
                if (unsigned_i) begin
                    result_o = {16'h0000, shifted_s[15:0]};
                end else begin
                    result_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end
            end
            default: result_o = shifted_s;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one decoded memory access against the DMEM port,
// stalling the pipeline until the access completes or is rejected.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_i,
    input  logic          mem_read_i,
    input  logic          mem_write_i,
    input  logic [3:0]    d_size_i,
    input  logic          d_unsigned_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic          stall_o,
    output logic          done_o,
    output logic          err_o,
    output logic [DW-1:0] rdata_o,
    output logic          dmem_req_o,
    output logic          dmem_we_o,
    output logic [3:0]    dmem_be_o,
    output logic [AW-1:0] dmem_addr_o,
    output logic [DW-1:0] dmem_wdata_o,
    input  logic          dmem_gnt_i,
    input  logic          dmem_rvalid_i,
    input  logic [DW-1:0] dmem_rdata_i
);

    lsu_state_e    state_q, state_d;

    logic          accept_s;
    logic          legal_s;
    logic          store_done_s;
    logic          load_done_s;
    logic [DW-1:0] fmt_s;

    logic [AW-1:0] addr_q;
    logic [1:0]    off_q;
    logic [3:0]    size_q;
    logic          uns_q;
    logic          we_q;
    logic [3:0]    be_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          done_q;

    // done_q keeps the instruction still sitting in EX during its completion
    // cycle from being taken a second time.
    assign accept_s     = (state_q == IDLE) & valid_i & (mem_read_i | mem_write_i) & ~done_q;
    assign legal_s      = lsu_size_legal(d_size_i, addr_i[1:0]) & ~(mem_read_i & mem_write_i);
    assign store_done_s = (state_q == REQ) & dmem_gnt_i & we_q;
    assign load_done_s  = (state_q == WAIT) & dmem_rvalid_i;

    lsu_load_align u_load_align (
        .rdata_i    (dmem_rdata_i),
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (fmt_s)
    );

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; gnt outside REQ and rvalid outside WAIT fall through unseen.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = legal_s ? REQ : ERR;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    state_d = we_q ? IDLE : WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; the error cycle releases the stall so the faulting instruction retires.
    always_comb begin
        dmem_req_o = 1'b0;
        err_o      = 1'b0;
        stall_o    = 1'b0;
        case (state_q)
            IDLE: stall_o = accept_s;
            REQ: begin
                dmem_req_o = 1'b1;
                stall_o    = 1'b1;
            end
            WAIT:    stall_o = 1'b1;
            ERR:     err_o   = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

    // Capture the access at accept; port-side address, enables and data are prepared here
    // so they stay stable for every REQ cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            off_q   <= 2'b00;
            size_q  <= 4'b0000;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
        end else if (accept_s) begin
            addr_q  <= {addr_i[AW-1:2], 2'b00};
            off_q   <= addr_i[1:0];
            size_q  <= d_size_i;
            uns_q   <= d_unsigned_i;
            we_q    <= mem_write_i;
            be_q    <= lsu_byte_en(d_size_i, addr_i[1:0]);
            wdata_q <= wdata_i << {addr_i[1:0], 3'b000};
        end else begin
            addr_q  <= addr_q;
            off_q   <= off_q;
            size_q  <= size_q;
            uns_q   <= uns_q;
            we_q    <= we_q;
            be_q    <= be_q;
            wdata_q <= wdata_q;
        end
    end

    // Completion pulse and load result; rdata keeps its value until the next load lands.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            done_q <= store_done_s | load_done_s;
            if (load_done_s) begin
                rdata_q <= fmt_s;
            end else begin
                rdata_q <= rdata_q;
            end
        end
    end

    assign done_o       = done_q;
    assign rdata_o      = rdata_q;
    assign dmem_we_o    = we_q;
    assign dmem_be_o    = be_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scoreboard of expected completions.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        mem_read_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic [3:0]  d_size_i = 4'b0000;
    logic        d_unsigned_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        stall_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic        dmem_req_o, dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_gnt_i = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = 32'h0;

    typedef struct {
        logic        is_err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_rdata = 32'h0;

    load_store_unit #(.AW(32), .DW(32)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .valid_i       (valid_i),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .d_size_i      (d_size_i),
        .d_unsigned_i  (d_unsigned_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .rdata_o       (rdata_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i     = 1'b0;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [3:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        valid_i      = 1'b1;
        mem_read_i   = rd;
        mem_write_i  = wr;
        d_size_i     = size;
        d_unsigned_i = uns;
        addr_i       = addr;
        wdata_i      = wdata;
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check1({tag, "_stall"}, stall_o, 1'b0);
        check1({tag, "_done"}, done_o, 1'b0);
        check1({tag, "_err"}, err_o, 1'b0);
        check1({tag, "_req"}, dmem_req_o, 1'b0);
    endtask

    // Expect a completion in the current cycle (within max_wait), pop and compare it.
    task automatic wait_result(input string tag, input int max_wait);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            if (done_o || err_o) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
        end else begin
            e = sb_q.pop_front();
            if (!seen) begin
                vectors++;
                miscompares++;
                $error("FAIL %s_timeout: observed no done/err expected completion", tag);
            end else begin
                check1({tag, "_err"}, err_o, e.is_err);
                check1({tag, "_done"}, done_o, ~e.is_err);
                check32({tag, "_rdata"}, rdata_o, e.rdata);
                check1({tag, "_stall_rel"}, stall_o, 1'b0);
                check1({tag, "_req_idle"}, dmem_req_o, 1'b0);
            end
        end
        idle_inputs();
        cyc();
        check1({tag, "_pulse_end"}, done_o | err_o, 1'b0);
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [3:0] size,
                            input logic [31:0] wdata, input int gd, input logic [3:0] exp_be,
                            input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
        issue(1'b0, 1'b1, size, 1'b0, addr, wdata);
        check1({tag, "_stall_acc"}, stall_o, 1'b1);
        sb_q.push_back('{1'b0, model_rdata});
        cyc();
        for (int i = 0; i <= gd; i++) begin
            check1({tag, "_req"}, dmem_req_o, 1'b1);
            check1({tag, "_we"}, dmem_we_o, 1'b1);
            check32({tag, "_be"}, {28'd0, dmem_be_o}, {28'd0, exp_be});
            check32({tag, "_addr"}, dmem_addr_o, exp_addr);
            check32({tag, "_wdata"}, dmem_wdata_o, exp_wdata);
            check1({tag, "_stall"}, stall_o, 1'b1);
            if (i == gd) dmem_gnt_i = 1'b1;
            cyc();
        end
        dmem_gnt_i = 1'b0;
        wait_result(tag, 1);
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [3:0] size,
                           input logic uns, input logic [31:0] raw, input int gd, input int rd,
                           input logic [3:0] exp_be, input logic [31:0] exp_val);
        logic [31:0] prev;
        prev = model_rdata;
        issue(1'b1, 1'b0, size, uns, addr, 32'h5A5A5A5A);
        check1({tag, "_stall_acc"}, stall_o, 1'b1);
        model_rdata = exp_val;
        sb_q.push_back('{1'b0, exp_val});
        cyc();
        for (int i = 0; i <= gd; i++) begin
            check1({tag, "_req"}, dmem_req_o, 1'b1);
            check1({tag, "_we"}, dmem_we_o, 1'b0);
            check32({tag, "_be"}, {28'd0, dmem_be_o}, {28'd0, exp_be});
            check32({tag, "_addr"}, dmem_addr_o, {addr[31:2], 2'b00});
            if (i == gd) dmem_gnt_i = 1'b1;
            cyc();
        end
        dmem_gnt_i = 1'b0;
        for (int i = 0; i < rd; i++) begin
            check1({tag, "_wait_req"}, dmem_req_o, 1'b0);
            check1({tag, "_wait_stall"}, stall_o, 1'b1);
            check32({tag, "_wait_rdata"}, rdata_o, prev);
            cyc();
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = raw;
        cyc();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
        wait_result(tag, 1);
    endtask

    task automatic do_err(input string tag, input logic rd, input logic wr,
                          input logic [3:0] size, input logic [31:0] addr);
        issue(rd, wr, size, 1'b0, addr, 32'h0);
        check1({tag, "_stall_acc"}, stall_o, 1'b1);
        sb_q.push_back('{1'b1, model_rdata});
        cyc();
        wait_result(tag, 1);
        check1({tag, "_no_req"}, dmem_req_o, 1'b0);
    endtask

    initial begin
        // Reset state
        cyc();
        cyc();
        check_quiet("rst");
        check32("rst_rdata", rdata_o, 32'h0);
        check32("rst_be", {28'd0, dmem_be_o}, 32'h0);
        check32("rst_addr", dmem_addr_o, 32'h0);
        check32("rst_wdata", dmem_wdata_o, 32'h0);
        check1("rst_we", dmem_we_o, 1'b0);
        rst_ni = 1'b1;
        cyc();

        do_store("sb_103", 32'h103, SIZE_B, 32'h000000A5, 0, 4'b1000, 32'h100, 32'hA5000000);
        do_load("lh_202_s", 32'h202, SIZE_H, 1'b0, 32'h80011234, 0, 0, 4'b1100, 32'hFFFF8001);
        do_load("lh_202_u", 32'h202, SIZE_H, 1'b1, 32'h80011234, 0, 0, 4'b1100, 32'h00008001);
        do_err("lw_006", 1'b1, 1'b0, SIZE_W, 32'h006);
        do_store("sw_040_gd3", 32'h040, SIZE_W, 32'h12345678, 3, 4'b1111, 32'h040, 32'h12345678);
        do_load("lb_001_rv4", 32'h001, SIZE_B, 1'b0, 32'h00008000, 0, 4, 4'b0010, 32'hFFFFFF80);
        do_load("lbu_003", 32'h003, SIZE_B, 1'b1, 32'h9A000000, 0, 0, 4'b1000, 32'h0000009A);
        do_load("lw_008", 32'h008, SIZE_W, 1'b0, 32'hCAFEF00D, 1, 1, 4'b1111, 32'hCAFEF00D);
        do_store("sh_0a2", 32'h0A2, SIZE_H, 32'h0000BEEF, 0, 4'b1100, 32'h0A0, 32'hBEEF0000);
        do_err("lh_003", 1'b1, 1'b0, SIZE_H, 32'h003);
        do_err("rd_wr", 1'b1, 1'b1, SIZE_B, 32'h000);
        do_err("bad_size", 1'b1, 1'b0, 4'b0111, 32'h000);

        // Stray grant while idle is ignored
        dmem_gnt_i = 1'b1;
        cyc();
        dmem_gnt_i = 1'b0;
        check_quiet("stray_gnt");
        check32("stray_gnt_rdata", rdata_o, model_rdata);

        // Reset while waiting for read data, then a stray rvalid
        issue(1'b1, 1'b0, SIZE_W, 1'b0, 32'h010, 32'h0);
        cyc();
        dmem_gnt_i = 1'b1;
        cyc();
        dmem_gnt_i = 1'b0;
        check1("rstw_in_wait_stall", stall_o, 1'b1);
        check1("rstw_in_wait_req", dmem_req_o, 1'b0);
        rst_ni = 1'b0;
        idle_inputs();
        cyc();
        check_quiet("rstw_reset");
        check32("rstw_reset_rdata", rdata_o, 32'h0);
        check32("rstw_reset_be", {28'd0, dmem_be_o}, 32'h0);
        check32("rstw_reset_addr", dmem_addr_o, 32'h0);
        rst_ni = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hDEADBEEF;
        cyc();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
        check_quiet("rstw_stray");
        check32("rstw_stray_rdata", rdata_o, 32'h0);
        cyc();
        check1("rstw_stray_done2", done_o, 1'b0);
        check32("rstw_stray_rdata2", rdata_o, 32'h0);
        model_rdata = 32'h0;

        // Normal operation resumes after the abandoned load
        do_store("sb_000_post", 32'h000, SIZE_B, 32'h00000011, 0, 4'b0001, 32'h000, 32'h00000011);

        check32("sb_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
